// File: rtl/lc3b_lsu_pkg.sv
// Shared types for the LC-3b load/store unit: memory op/size encodings and FSM states.
package lc3b_types;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } lc3b_mem_op;

  typedef enum logic {
    MEM_WORD = 1'b0,
    MEM_BYTE = 1'b1
  } lc3b_mem_size;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_PTR    = 2'd1,
    LSU_ACCESS = 2'd2,
    LSU_DONE   = 2'd3
  } lc3b_lsu_state;

endpackage

// File: rtl/lc3b_lsu_lane_align.sv
// Byte-lane steering for the LSU: load lane extract/zero-extend, store replicate and byte-enable decode.
module lsu_lane_align #(
  parameter  int WIDTH     = 16,
  localparam int BYTES     = WIDTH / 8,
  localparam int LANE_BITS = $clog2(BYTES)
) (
  input  logic [LANE_BITS-1:0] ld_lane,
  input  logic [WIDTH-1:0]     ld_word,
  output logic [WIDTH-1:0]     ld_data,
  input  logic [LANE_BITS-1:0] st_lane,
  input  logic [7:0]           st_byte,
  output logic [WIDTH-1:0]     st_data,
  output logic [BYTES-1:0]     st_be
);

  logic [7:0] ld_byte;

  assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
  assign ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
  assign st_data = {BYTES{st_byte}};
  assign st_be   = BYTES'(1) << st_lane;

endmodule

// File: rtl/lc3b_lsu.sv
// LC-3b load/store unit: MAR/MDR, request FSM and handshaked memory port.
// Optional LDI/STI pointer fetch is built only when LSU_INDIRECT_EN is defined.
module lc3b_lsu
  import lc3b_types::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  op,
  input  logic                  size,
  input  logic                  indirect,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic                  done,
  output logic [WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [WIDTH/8-1:0]    mem_byte_enable,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_resp,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int BYTES     = WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);

  lc3b_lsu_state state, state_next;
  lc3b_mem_op    op_q;
  lc3b_mem_size  size_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [LANE_BITS-1:0] lane_q;

  lc3b_mem_op           acc_op;
  lc3b_mem_size         acc_size;
  logic [WIDTH-1:0]     acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] acc_eff_addr;
  logic [LANE_BITS-1:0] acc_lane;
  logic [BYTES-1:0]     acc_be;
  logic [WIDTH-1:0]     acc_mdr;
  logic [WIDTH-1:0]     ld_data, st_data;
  logic [BYTES-1:0]     st_be;

  logic go_ptr, start, start_ptr, ptr_done, start_access, access_done;

`ifdef LSU_INDIRECT_EN
  assign go_ptr   = indirect;
  assign ptr_done = (state == LSU_PTR) && mem_resp;
`else
  logic unused_indirect;
  assign unused_indirect = indirect;
  assign go_ptr          = 1'b0;
  assign ptr_done        = 1'b0;
`endif

  assign start        = (state == LSU_IDLE) && req;
  assign start_ptr    = start && go_ptr;
  assign start_access = (start && !go_ptr) || ptr_done;
  assign access_done  = (state == LSU_ACCESS) && mem_resp;

  // Access parameters come from the request port when starting, or from the
  // latched request plus the fetched pointer when leaving the pointer read.
  always_comb begin
    acc_op    = lc3b_mem_op'(op);
    acc_size  = lc3b_mem_size'(size);
    acc_wdata = wdata;
    acc_addr  = addr;
    if (state != LSU_IDLE) begin
      acc_op    = op_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
      acc_addr  = mem_rdata[ADDR_WIDTH-1:0];
    end
  end

  assign acc_lane     = acc_addr[LANE_BITS-1:0];
  assign acc_eff_addr = (acc_size == MEM_BYTE) ? acc_addr : (acc_addr & ~LANE_MASK);
  assign acc_be       = (acc_size == MEM_BYTE) ? st_be : '1;
  assign acc_mdr      = (acc_size == MEM_BYTE) ? st_data : acc_wdata;

  lsu_lane_align #(.WIDTH(WIDTH)) u_align (
    .ld_lane (lane_q),
    .ld_word (mem_rdata),
    .ld_data (ld_data),
    .st_lane (acc_lane),
    .st_byte (acc_wdata[7:0]),
    .st_data (st_data),
    .st_be   (st_be)
  );

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE:   if (req) state_next = go_ptr ? LSU_PTR : LSU_ACCESS;
`ifdef LSU_INDIRECT_EN
      LSU_PTR:    if (mem_resp) state_next = LSU_ACCESS;
`endif
      LSU_ACCESS: if (mem_resp) state_next = LSU_DONE;
      LSU_DONE:   state_next = LSU_IDLE;
      default:    state_next = LSU_IDLE;
    endcase
  end

  // Memory-side outputs are registered at the edge that enters the state
  // using them, so they are valid for the whole state and stable across waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= LSU_IDLE;
      op_q            <= MEM_LOAD;
      size_q          <= MEM_WORD;
      wdata_q         <= '0;
      lane_q          <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      rdata           <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        op_q    <= lc3b_mem_op'(op);
        size_q  <= lc3b_mem_size'(size);
        wdata_q <= wdata;
      end
      if (start_ptr) begin
        mem_address     <= addr & ~LANE_MASK;
        mem_byte_enable <= '1;
        mem_read        <= 1'b1;
        mem_write       <= 1'b0;
      end
      if (start_access) begin
        mem_address     <= acc_eff_addr;
        lane_q          <= acc_lane;
        mem_byte_enable <= acc_be;
        mem_read        <= (acc_op == MEM_LOAD);
        mem_write       <= (acc_op == MEM_STORE);
        if (acc_op == MEM_STORE) mem_wdata <= acc_mdr;
      end
      if (access_done) begin
        mem_read        <= 1'b0;
        mem_write       <= 1'b0;
        mem_byte_enable <= '0;
        if (op_q == MEM_LOAD) rdata <= (size_q == MEM_BYTE) ? ld_data : mem_rdata;
      end
    end
  end

  assign ready = (state == LSU_IDLE);
  assign done  = (state == LSU_DONE);

endmodule
